pair_unswapper: RTL and testbench
=================================

// Module: pair_unswapper
// PURPOSE
// - Receive end of the pairwise-swap scrambler: restores the original N-bit word from a scrambled word
//   plus the per-pair swap decisions that produced it.
// - Pair k = bits {2k+1,2k}; swap_i[k]=1 means that pair was exchanged and must be exchanged back.
// - Sits between the scrambler output and the checker/scoreboard. Decouples them with a 2-entry buffer
//   under valid/ready flow control.
// PARAMETERS
// - N      10  word width; odd N allowed, top bit N-1 has no partner and always passes straight through
// - CNT_W  16  width of the delivered-word counter
// PORTS
// - clk          in   1          single clock, rising edge
// - reset_n      in   1          asynchronous active-low reset
// - x_i          in   N          scrambled word
// - swap_i       in   N/2        per-pair swap decisions, floor(N/2) bits
// - valid_i      in   1          x_i/swap_i valid
// - ready_o      out  1          buffer can accept; registered
// - x_o          out  N          restored word
// - valid_o      out  1          x_o valid; registered
// - ready_i      in   1          downstream accepts
// - word_cnt_o   out  CNT_W      count of words delivered (valid_o & ready_i)
// - par_i        in   1          even parity of the original word (PARITY_CHECK_EN only)
// - par_err_o    out  1          sticky parity error flag (PARITY_CHECK_EN only)
// BEHAVIOUR
// - Reset (async assert, sync-free release): state=EMPTY, ready_o=1, valid_o=0, x_o=0, word_cnt_o=0,
//   par_err_o=0. Asserting reset mid-operation discards buffered words immediately.
// - Unswap happens on the write path: entry = x_i with pair k exchanged iff swap_i[k]. Pure bit permutation.
// - Push = valid_i & ready_o. Pop = valid_o & ready_i. x_i is sampled only on push.
// - Latency: a word pushed at edge t appears on x_o with valid_o=1 right after edge t (1 cycle).
// - FSM states:
//   - EMPTY (valid_o=0, ready_o=1): push -> ONE.
//   - ONE (valid_o=1, ready_o=1):
//     - push only -> FULL
//     - pop only -> EMPTY
//     - push & pop -> ONE; the new word becomes the head.
//   - FULL (valid_o=1, ready_o=0): pop -> ONE; the second entry becomes the head. A valid_i in FULL is ignored.
// - Order preserved; no word dropped or duplicated. x_o is stable while valid_o=1 and ready_i=0.
// - word_cnt_o increments by 1 per pop and wraps from 2^CNT_W-1 to 0.
// - Upstream must hold x_i/swap_i/valid_i stable while valid_i=1 and ready_o=0.
// CONFIGURATION
// - PARITY_CHECK_EN defined:
//   - par_i is stored alongside each entry.
//   - On pop, if ^x_o != stored par_i then par_err_o is set to 1 on the next edge.
//   - par_err_o stays set until reset.
// - PARITY_CHECK_EN undefined:
//   - par_i/par_err_o ports are absent; no parity storage.
// TESTING
// - Unswap, N=10:
//   - x_i=10'b10_01_11_00_01, swap_i=5'b10011 -> x_o=10'b01_01_11_00_10, one cycle later.
// - Odd width, N=5:
//   - x_i=5'b1_10_01, swap_i=2'b11 -> x_o=5'b1_01_10; bit 4 is untouched.
// - Backpressure:
//   - Push A, B with ready_i=0 -> ready_o=0 after B and x_o holds A.
//   - Then ready_i=1 -> A, B delivered in order; word_cnt_o=2.
// - Streaming: valid_i=1 and ready_i=1 for 100 cycles -> 100 words in order, ready_o stays 1, word_cnt_o=100.
// - Counter wrap: CNT_W=4, deliver 17 words -> word_cnt_o=1.
// - Reset mid-operation: FULL state, assert reset_n=0 between edges -> valid_o=0 and ready_o=1 immediately;
//   nothing delivered after release until a new push.
// - PARITY_CHECK_EN: push a word with wrong par_i -> par_err_o=1 on the edge after its pop; stays 1 until reset.

Source files
------------

// File: rtl/pair_unswapper.sv
// pair_unswapper: receive side of the pairwise-swap scrambler.
// Restores the original word by exchanging back every pair k = {2k+1,2k}
// flagged in swap_i, then buffers it in a 2-entry valid/ready skid buffer.
// The head entry is the registered output x_o; the second entry backs it up.
// Optional feature macro: PARITY_CHECK_EN (adds par_i / par_err_o and
// per-entry parity storage with a sticky error flag).
//
// state | meaning
// EMPTY | no word buffered; valid_o=0, ready_o=1
// ONE   | head entry valid;   valid_o=1, ready_o=1
// FULL  | both entries valid; valid_o=1, ready_o=0
module pair_unswapper #(
  parameter int N     = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     x_i,
  input  logic [N/2-1:0]   swap_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [N-1:0]     x_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] word_cnt_o
`ifdef PARITY_CHECK_EN
  ,
  input  logic             par_i,
  output logic             par_err_o
`endif
);

  localparam int SW = N / 2;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t       state;
  logic [N-1:0] x_un;
  logic [N-1:0] x_sec;
  logic         push;
  logic         pop;
  logic         load_head_new;
  logic         load_head_sec;
  logic         load_sec;

  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i;

  // Head takes the incoming word when the buffer is empty or is being replaced
  // in the same cycle; the second entry only fills while the head is held.
  assign load_head_new = push & ((state == EMPTY) | ((state == ONE) & pop));
  assign load_head_sec = (state == FULL) & pop;
  assign load_sec      = (state == ONE) & push & ~pop;

  // Undo the swap: a pure bit permutation, the unpaired top bit of odd N passes through.
  always_comb begin
    x_un = x_i;
    for (int k = 0; k < SW; k++) begin
      if (swap_i[k]) begin
        x_un[2*k]   = x_i[2*k+1];
        x_un[2*k+1] = x_i[2*k];
      end
    end
  end

  // Occupancy FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= EMPTY;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state   <= ONE;
            valid_o <= 1'b1;
            ready_o <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state   <= FULL;
            ready_o <= 1'b0;
          end else if (pop && !push) begin
            state   <= EMPTY;
            valid_o <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            state   <= ONE;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

  // Data entries; x_o only changes on a load so it holds under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_o   <= '0;
      x_sec <= '0;
    end else begin
      if (load_head_new) begin
        x_o <= x_un;
      end else if (load_head_sec) begin
        x_o <= x_sec;
      end
      if (load_sec) begin
        x_sec <= x_un;
      end
    end
  end

  // Delivered-word counter, wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt_o <= '0;
    end else if (pop) begin
      word_cnt_o <= word_cnt_o + CNT_ONE;
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_head;
  logic par_sec;

  // Parity travels with its word; a mismatch on delivery latches the error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_head  <= 1'b0;
      par_sec   <= 1'b0;
      par_err_o <= 1'b0;
    end else begin
      if (load_head_new) begin
        par_head <= par_i;
      end else if (load_head_sec) begin
        par_head <= par_sec;
      end
      if (load_sec) begin
        par_sec <= par_i;
      end
      if (pop && ((^x_o) != par_head)) begin
        par_err_o <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pair_unswapper.sv
// Bench for pair_unswapper: N=10 instance checked against a scoreboard of
// independently unswapped words, plus an N=5 / CNT_W=4 instance for the
// odd-width and counter-wrap cases. Parity checks compile under PARITY_CHECK_EN.
module tb_pair_unswapper;

  logic        clk = 1'b0;
  logic        reset_n;

  logic [9:0]  x_i;
  logic [4:0]  swap_i;
  logic        valid_i, ready_i;
  logic        ready_o, valid_o;
  logic [9:0]  x_o;
  logic [15:0] word_cnt_o;

  logic [4:0]  x2_i;
  logic [1:0]  s2_i;
  logic        v2_i, r2_i;
  logic        rdy2_o, v2_o;
  logic [4:0]  x2_o;
  logic [3:0]  cnt2_o;

`ifdef PARITY_CHECK_EN
  logic par_i, par_err_o, par2_i, par2_err_o;
  logic par_flip;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] q[$];
  int exp_cnt = 0;
  logic blocked = 1'b0;

  always #5 clk = ~clk;

  pair_unswapper #(.N(10), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .x_i(x_i), .swap_i(swap_i), .valid_i(valid_i),
    .ready_o(ready_o), .x_o(x_o), .valid_o(valid_o), .ready_i(ready_i),
    .word_cnt_o(word_cnt_o)
`ifdef PARITY_CHECK_EN
    , .par_i(par_i), .par_err_o(par_err_o)
`endif
  );

  pair_unswapper #(.N(5), .CNT_W(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .x_i(x2_i), .swap_i(s2_i), .valid_i(v2_i),
    .ready_o(rdy2_o), .x_o(x2_o), .valid_o(v2_o), .ready_i(r2_i),
    .word_cnt_o(cnt2_o)
`ifdef PARITY_CHECK_EN
    , .par_i(par2_i), .par_err_o(par2_err_o)
`endif
  );

  function automatic logic [9:0] unswap_m(input logic [9:0] x, input logic [4:0] s);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = s[i/2] ? x[i ^ 1] : x[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on the N=10 instance; called at posedge+1.
  task automatic cycle(input logic vi, input logic [9:0] x, input logic [4:0] s, input logic ri);
    valid_i = vi; x_i = x; swap_i = s; ready_i = ri;
`ifdef PARITY_CHECK_EN
    par_i = (^x) ^ par_flip;
`endif
    @(negedge clk);
    if (valid_o && ready_i) begin
      if (q.size() == 0) begin
        chk("pop_without_push", 32'(x_o), 32'hFFFF_FFFF);
      end else begin
        chk("data_order", 32'(x_o), 32'(q.pop_front()));
      end
      exp_cnt++;
    end
    blocked = valid_i && !ready_o;
    if (valid_i && ready_o) q.push_back(unswap_m(x, s));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cycle(1'b0, 10'h0, 5'h0, 1'b1);
    chk("drained_queue", 32'(q.size()), 32'd0);
    chk("drained_valid", 32'(valid_o), 32'd0);
  endtask

  initial begin
    logic [9:0] wa, wb, hx;
    logic [4:0] sa, sb, hs;
    logic       hv;
    int         delivered;

    reset_n = 1'b0;
    x_i = '0; swap_i = '0; valid_i = 1'b0; ready_i = 1'b0;
    x2_i = '0; s2_i = '0; v2_i = 1'b0; r2_i = 1'b0;
`ifdef PARITY_CHECK_EN
    par_i = 1'b0; par2_i = 1'b0; par_flip = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_x", 32'(x_o), 32'd0);
    chk("rst_cnt", 32'(word_cnt_o), 32'd0);
`ifdef PARITY_CHECK_EN
    chk("rst_par_err", 32'(par_err_o), 32'd0);
`endif
    reset_n = 1'b1;

    // Worked unswap example, one cycle latency.
    cycle(1'b1, 10'b10_01_11_00_01, 5'b10011, 1'b1);
    chk("unswap_valid", 32'(valid_o), 32'd1);
    chk("unswap_ex", 32'(x_o), 32'(10'b01_01_11_00_10));
    drain();

    // Backpressure: two words fill the buffer, head holds.
    wa = 10'h2A5; sa = 5'b01101; wb = 10'h1C3; sb = 5'b11010;
    cycle(1'b1, wa, sa, 1'b0);
    cycle(1'b1, wb, sb, 1'b0);
    chk("bp_ready_low", 32'(ready_o), 32'd0);
    chk("bp_head_a", 32'(x_o), 32'(unswap_m(wa, sa)));
    cycle(1'b0, 10'h0, 5'h0, 1'b0);
    chk("bp_head_hold", 32'(x_o), 32'(unswap_m(wa, sa)));
    drain();
    chk("bp_cnt", 32'(word_cnt_o), 32'd3);

    // Streaming 100 words back to back.
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 10'($urandom), 5'($urandom), 1'b1);
      chk("stream_ready", 32'(ready_o), 32'd1);
    end
    drain();
    chk("stream_cnt", 32'(word_cnt_o), 32'd103);

    // Random traffic; upstream holds a blocked word stable.
    hv = 1'b0; hx = '0; hs = '0;
    for (int i = 0; i < 300; i++) begin
      if (!blocked) begin
        hv = 1'($urandom_range(0, 1));
        hx = 10'($urandom);
        hs = 5'($urandom);
      end
      cycle(hv, hx, hs, 1'($urandom_range(0, 2) != 0));
    end
    drain();
    chk("random_cnt", 32'(word_cnt_o), 32'(exp_cnt));
`ifdef PARITY_CHECK_EN
    chk("par_clean", 32'(par_err_o), 32'd0);
`endif

    // Reset while FULL: outputs clear immediately, nothing delivered after.
    cycle(1'b1, 10'h155, 5'h0A, 1'b0);
    cycle(1'b1, 10'h0F0, 5'h15, 1'b0);
    chk("pre_rst_full", 32'(ready_o), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_ready", 32'(ready_o), 32'd1);
    chk("midrst_x", 32'(x_o), 32'd0);
    q.delete(); exp_cnt = 0; blocked = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 10'h0, 5'h0, 1'b1);
      chk("postrst_idle", 32'(valid_o), 32'd0);
    end
    chk("postrst_cnt", 32'(word_cnt_o), 32'd0);

    // Odd width: bit 4 has no partner.
    v2_i = 1'b1; x2_i = 5'b1_10_01; s2_i = 2'b11; r2_i = 1'b0;
    @(posedge clk); #1;
    chk("odd_valid", 32'(v2_o), 32'd1);
    chk("odd_unswap", 32'(x2_o), 32'(5'b1_01_10));

    // Counter wrap with CNT_W=4: 17 deliveries leave 1.
    delivered = 0;
    r2_i = 1'b1;
    for (int i = 0; i < 100 && delivered < 17; i++) begin
      @(negedge clk);
      if (v2_o) delivered++;
      @(posedge clk); #1;
      x2_i = 5'($urandom);
    end
    v2_i = 1'b0; r2_i = 1'b0;
    chk("wrap_delivered", 32'(delivered), 32'd17);
    chk("wrap_cnt", 32'(cnt2_o), 32'd1);

`ifdef PARITY_CHECK_EN
    // Wrong parity on one word: flag rises after its pop and stays.
    par_flip = 1'b1;
    cycle(1'b1, 10'h3C7, 5'h09, 1'b0);
    par_flip = 1'b0;
    chk("par_before_pop", 32'(par_err_o), 32'd0);
    cycle(1'b0, 10'h0, 5'h0, 1'b1);
    chk("par_err_set", 32'(par_err_o), 32'd1);
    drain();
    chk("par_err_sticky", 32'(par_err_o), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("par_err_rst", 32'(par_err_o), 32'd0);
    reset_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
